// File: rtl/bram_tensor_pingpong_if.sv
// Purpose: bundles the tensor store's streaming write side and indexed read side.
// Latency: none; wires only.
// Backpressure: wr_ready gates writes; reads have no backpressure.
interface bram_tensor_pingpong_if #(
    parameter int BW = 16,
    parameter int D0 = 10,
    parameter int D1 = 3,
    parameter int D2 = 5,
    parameter int D3 = 5
);
    localparam int IW0 = ($clog2(D0) > 1) ? $clog2(D0) : 1;
    localparam int IW1 = ($clog2(D1) > 1) ? $clog2(D1) : 1;
    localparam int IW2 = ($clog2(D2) > 1) ? $clog2(D2) : 1;
    localparam int IW3 = ($clog2(D3) > 1) ? $clog2(D3) : 1;

    logic           wr_valid;
    logic [BW-1:0]  wr_data;
    logic           wr_ready;
    logic           rd_en;
    logic [IW0-1:0] rd_i0;
    logic [IW1-1:0] rd_i1;
    logic [IW2-1:0] rd_i2;
    logic [IW3-1:0] rd_i3;
    logic           rd_release;
    logic [BW-1:0]  rd_data;
    logic           rd_valid;
    logic           err_oob;
    logic           bank_ready;
    logic           wr_bank;
    logic           rd_bank;

    // Producer/consumer side (loader + PE array).
    modport master (
        output wr_valid, wr_data, rd_en, rd_i0, rd_i1, rd_i2, rd_i3, rd_release,
        input  wr_ready, rd_data, rd_valid, err_oob, bank_ready, wr_bank, rd_bank
    );

    // Storage side.
    modport slave (
        input  wr_valid, wr_data, rd_en, rd_i0, rd_i1, rd_i2, rd_i3, rd_release,
        output wr_ready, rd_data, rd_valid, err_oob, bank_ready, wr_bank, rd_bank
    );
endinterface

// File: rtl/bram_tensor_pingpong.sv
// Purpose: double-buffered 4-D tensor store; streamed row-major fill, indexed read, auto bank swap.
// Latency: read data 1 cycle after rd_en; swap takes effect the edge after the last beat or release.
// Backpressure: wr_ready drops only while a full tensor waits for the reader to release its bank.
module bram_tensor_pingpong #(
    parameter int BW = 16,
    parameter int D0 = 10,
    parameter int D1 = 3,
    parameter int D2 = 5,
    parameter int D3 = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    bram_tensor_pingpong_if.slave  bus
);
    localparam int DEPTH = D0 * D1 * D2 * D3;
    localparam int AW    = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    localparam logic [AW:0]   D1_A = (AW + 1)'(D1);
    localparam logic [AW:0]   D2_A = (AW + 1)'(D2);
    localparam logic [AW:0]   D3_A = (AW + 1)'(D3);

    typedef enum logic {FILL, HOLD} wstate_t;

    wstate_t        state, state_nxt;
    logic [AW-1:0]  wcnt;
    logic           bank_ready_q;
    logic           wr_bank_q;
    logic           rd_bank_q;
    logic           wr_fire;
    logic           swap;
    logic [BW-1:0]  rd_data_q;
    logic           rd_valid_q;
    logic           err_oob_q;

    // Both banks in one array; contents are deliberately left unreset.
    logic [BW-1:0]  mem [0:1][0:DEPTH-1];

    // Read-side address decode: range check on each index, then row-major linearisation
    // one bit wider than the store so an oversize result cannot alias a valid address.
    logic [31:0]    i0_w, i1_w, i2_w, i3_w;
    logic [AW:0]    addr_full;
    logic           idx_oob;
    logic           oob;
    logic [AW-1:0]  raddr;

    assign i0_w = 32'(bus.rd_i0);
    assign i1_w = 32'(bus.rd_i1);
    assign i2_w = 32'(bus.rd_i2);
    assign i3_w = 32'(bus.rd_i3);

    assign idx_oob   = (i0_w >= 32'(D0)) || (i1_w >= 32'(D1)) ||
                       (i2_w >= 32'(D2)) || (i3_w >= 32'(D3));
    assign addr_full = ((((AW + 1)'(bus.rd_i0) * D1_A + (AW + 1)'(bus.rd_i1)) * D2_A
                         + (AW + 1)'(bus.rd_i2)) * D3_A) + (AW + 1)'(bus.rd_i3);
    assign oob       = idx_oob || addr_full[AW];
    assign raddr     = oob ? '0 : addr_full[AW-1:0];

    assign wr_fire = bus.wr_valid && (state == FILL);

    // Writer next-state: a finished tensor swaps in directly if the read bank is free
    // (or being released this cycle), otherwise it parks in HOLD until release.
    always_comb begin
        state_nxt = state;
        swap      = 1'b0;
        unique case (state)
            FILL: begin
                if (wr_fire && (wcnt == LAST)) begin
                    if (!bank_ready_q || bus.rd_release) begin
                        swap = 1'b1;
                    end else begin
                        state_nxt = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.rd_release) begin
                    swap      = 1'b1;
                    state_nxt = FILL;
                end
            end
        endcase
    end

    // Writer state, beat counter and bank ownership.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= FILL;
            wcnt         <= '0;
            bank_ready_q <= 1'b0;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b1;
        end else begin
            state <= state_nxt;
            if (wr_fire) begin
                wcnt <= (wcnt == LAST) ? '0 : wcnt + 1'b1;
            end
            if (swap) begin
                bank_ready_q <= 1'b1;
                rd_bank_q    <= wr_bank_q;
                wr_bank_q    <= ~wr_bank_q;
            end else if (bus.rd_release) begin
                bank_ready_q <= 1'b0;
            end
        end
    end

    // Streamed write into the bank being filled.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_bank_q][wcnt] <= bus.wr_data;
        end
    end

    // Registered indexed read from the pre-edge read bank; data holds when no tensor is ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            err_oob_q  <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_en && bank_ready_q;
            err_oob_q  <= bus.rd_en && bank_ready_q && oob;
            if (bus.rd_en && bank_ready_q) begin
                rd_data_q <= oob ? '0 : mem[rd_bank_q][raddr];
            end
        end
    end

    assign bus.wr_ready   = (state == FILL);
    assign bus.rd_data    = rd_data_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.err_oob    = err_oob_q;
    assign bus.bank_ready = bank_ready_q;
    assign bus.wr_bank    = wr_bank_q;
    assign bus.rd_bank    = rd_bank_q;
endmodule

// File: tb/tb_bram_tensor_pingpong.sv
module tb_bram_tensor_pingpong;
    localparam int BW    = 16;
    localparam int D0    = 2;
    localparam int D1    = 3;
    localparam int D2    = 2;
    localparam int D3    = 2;
    localparam int DEPTH = D0 * D1 * D2 * D3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bram_tensor_pingpong_if #(.BW(BW), .D0(D0), .D1(D1), .D2(D2), .D3(D3)) tif ();

    bram_tensor_pingpong #(.BW(BW), .D0(D0), .D1(D1), .D2(D2), .D3(D3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (tif)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int            due;
        logic [BW-1:0] data;
        logic          oob;
    } exp_t;
    exp_t sb[$];

    // Reference model: the readable tensor, an optional finished tensor waiting for the
    // reader, and the partial tensor being streamed in.
    logic [BW-1:0] m_cur  [DEPTH];
    logic [BW-1:0] m_pend [DEPTH];
    logic [BW-1:0] m_fill [$];
    bit            m_cur_vld  = 0;
    bit            m_pend_vld = 0;
    int            m_swaps    = 0;
    logic [BW-1:0] m_last     = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every read response is matched against the scoreboard in order.
    exp_t me;
    always @(negedge clk) begin
        if (rst_n) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                me = sb.pop_front();
                chk("rd_valid", 32'(tif.rd_valid), 32'd1);
                chk("rd_data", 32'(tif.rd_data), 32'(me.data));
                chk("err_oob", 32'(tif.err_oob), 32'(me.oob));
            end else begin
                chk("rd_valid_idle", 32'(tif.rd_valid), 32'd0);
                chk("err_oob_idle", 32'(tif.err_oob), 32'd0);
            end
        end
    end

    task automatic check_status(input string tag);
        chk({tag, ":bank_ready"}, 32'(tif.bank_ready), 32'(m_cur_vld));
        chk({tag, ":wr_ready"}, 32'(tif.wr_ready), 32'(!m_pend_vld));
        chk({tag, ":rd_bank"}, 32'(tif.rd_bank), 32'(1 ^ (m_swaps & 1)));
        chk({tag, ":wr_bank"}, 32'(tif.wr_bank), 32'(m_swaps & 1));
    endtask

    // One clock of stimulus; the model is advanced with the same inputs.
    task automatic cycle(input bit wv, input logic [BW-1:0] wd, input bit re,
                         input int i0, input int i1, input int i2, input int i3, input bit rel);
        exp_t e;
        bit   nobank = 0;
        bit   done   = 0;
        int   a;
        tif.wr_valid   = wv;
        tif.wr_data    = wd;
        tif.rd_en      = re;
        tif.rd_i0      = i0[0:0];
        tif.rd_i1      = i1[1:0];
        tif.rd_i2      = i2[0:0];
        tif.rd_i3      = i3[0:0];
        tif.rd_release = rel;
        if (re) begin
            if (m_cur_vld) begin
                e.due = cyc + 1;
                if (i0 >= D0 || i1 >= D1 || i2 >= D2 || i3 >= D3) begin
                    e.data = '0;
                    e.oob  = 1'b1;
                end else begin
                    a      = ((i0 * D1 + i1) * D2 + i2) * D3 + i3;
                    e.data = m_cur[a];
                    e.oob  = 1'b0;
                end
                m_last = e.data;
                sb.push_back(e);
            end else begin
                nobank = 1;
            end
        end
        if (wv && !m_pend_vld) begin
            m_fill.push_back(wd);
            if (m_fill.size() == DEPTH) begin
                done = 1;
                if (!m_cur_vld || rel) begin
                    for (int k = 0; k < DEPTH; k++) m_cur[k] = m_fill[k];
                    m_cur_vld = 1;
                    m_swaps++;
                end else begin
                    for (int k = 0; k < DEPTH; k++) m_pend[k] = m_fill[k];
                    m_pend_vld = 1;
                end
                m_fill.delete();
            end
        end
        if (rel && !done) begin
            if (m_pend_vld) begin
                for (int k = 0; k < DEPTH; k++) m_cur[k] = m_pend[k];
                m_pend_vld = 0;
                m_swaps++;
            end else begin
                m_cur_vld = 0;
            end
        end
        @(posedge clk);
        #1;
        check_status("cyc");
        if (nobank) begin
            chk("nobank_rd_valid", 32'(tif.rd_valid), 32'd0);
            chk("nobank_rd_data_hold", 32'(tif.rd_data), 32'(m_last));
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, '0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rd(input int i0, input int i1, input int i2, input int i3);
        cycle(0, '0, 1, i0, i1, i2, i3, 0);
    endtask

    task automatic load(input int base, input bit rel_last);
        for (int k = 0; k < DEPTH; k++)
            cycle(1, BW'(base + k), 0, 0, 0, 0, 0, rel_last && (k == DEPTH - 1));
    endtask

    task automatic do_reset();
        tif.wr_valid   = 0;
        tif.rd_en      = 0;
        tif.rd_release = 0;
        rst_n          = 0;
        m_cur_vld      = 0;
        m_pend_vld     = 0;
        m_fill.delete();
        m_swaps        = 0;
        m_last         = '0;
        sb.delete();
        #1;
        chk("async_rst:bank_ready", 32'(tif.bank_ready), 32'd0);
        chk("async_rst:rd_valid", 32'(tif.rd_valid), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        check_status("post_rst");
        chk("post_rst:rd_data", 32'(tif.rd_data), 32'd0);
        chk("post_rst:err_oob", 32'(tif.err_oob), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        tif.wr_valid   = 0;
        tif.wr_data    = '0;
        tif.rd_en      = 0;
        tif.rd_i0      = '0;
        tif.rd_i1      = '0;
        tif.rd_i2      = '0;
        tif.rd_i3      = '0;
        tif.rd_release = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Reads with no tensor ready are ignored and rd_data stays 0.
        rd(0, 0, 0, 0);
        rd(1, 2, 1, 1);

        // First load, then a known read: (1,2,1,0) -> 22.
        load(0, 0);
        rd(1, 2, 1, 0);

        // Second load without release parks in HOLD; reads still see the first tensor.
        load(100, 0);
        for (int k = 0; k < 6; k++)
            cycle(1, 16'hdead, 1, $urandom_range(0, 1), $urandom_range(0, 2),
                  $urandom_range(0, 1), $urandom_range(0, 1), 0);
        cycle(0, '0, 0, 0, 0, 0, 0, 1);
        rd(0, 0, 0, 1);

        // Release on the same cycle as the final beat: direct swap, no stall.
        load(300, 1);
        rd(0, 0, 0, 0);
        rd(1, 2, 1, 1);

        // Out-of-range index on dimension 1, then an in-range read.
        rd(0, 3, 0, 0);
        rd(1, 0, 1, 1);

        // Read together with release returns the released tensor's data.
        cycle(0, '0, 1, 1, 1, 0, 0, 1);
        rd(0, 1, 0, 0);

        // Partial fill with gaps, then reset discards it.
        acc = 0;
        while (acc < 10) begin
            if ($urandom_range(0, 1) == 1) begin
                cycle(1, BW'(500 + acc), 0, 0, 0, 0, 0, 0);
                acc++;
            end else begin
                idle(1);
            end
        end
        do_reset();
        load(200, 0);
        rd(0, 0, 0, 0);
        rd(1, 2, 1, 1);

        // Randomised traffic: gappy writes, random reads (including out-of-range), occasional release.
        for (int k = 0; k < 400; k++)
            cycle(($urandom_range(0, 3) != 0), BW'($urandom), $urandom_range(0, 1),
                  $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
                  $urandom_range(0, 1), ($urandom_range(0, 15) == 0));

        idle(3);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/bram_tensor_pingpong.md
Name: bram_tensor_pingpong

Overview:
- Parametrised double-buffered on-chip tensor store for one CNN layer. Replaces the per-type weight, ifmap and ofmap stores with one block whose 4-D shape (D0×D1×D2×D3) is set by parameters.
- Upstream streams elements in row-major order (D0 slowest) into the write bank. Downstream does random-access indexed reads from the read bank.
- Banks swap automatically, so the loader can fill the next tensor while the PE array consumes the current one.

Parameters:
- BW, 16, element width (BF16).
- D0, 10, outermost dimension (K filters, or channels for fmaps).
- D1, 3, second dimension (C; set 1 for 3-D fmaps).
- D2, 5, row dimension (wH / iH / oH).
- D3, 5, column dimension.
- Derived localparams:
  - DEPTH = D0*D1*D2*D3.
  - AW = max(1, $clog2(DEPTH)).
  - IWn = max(1, $clog2(Dn)) for n = 0..3.

Ports:
- clk  in  1  posedge clock
- rst_n  in  1  asynchronous active-low reset
- wr_valid  in  1  write element offered
- wr_data  in  BW  write element
- wr_ready  out  1  write bank can accept
- rd_en  in  1  read request
- rd_i0  in  IW0  index, dimension 0
- rd_i1  in  IW1  index, dimension 1
- rd_i2  in  IW2  index, dimension 2
- rd_i3  in  IW3  index, dimension 3
- rd_release  in  1  reader finished with current read bank
- rd_data  out  BW  registered read data
- rd_valid  out  1  rd_data valid (1-cycle pulse per request)
- err_oob  out  1  out-of-range index on the request just returned
- bank_ready  out  1  read bank holds a complete tensor
- wr_bank  out  1  bank index currently being written
- rd_bank  out  1  bank index currently readable

Behaviour:
- Storage: 2 banks × DEPTH × BW, inferred as BRAM.
  - Memory contents are NOT reset; only control state is reset.
- Reset values (async, rst_n low): wr_ready=1 once released, rd_data=0, rd_valid=0, err_oob=0, bank_ready=0, wr_bank=0, rd_bank=1, write counter=0, writer state=FILL.
- Write:
  - Beat accepted when wr_valid && wr_ready.
  - Data goes to mem[wr_bank][wcnt]; wcnt increments by 1.
  - Linear address order is row-major: ((i0*D1+i1)*D2+i2)*D3+i3.
- Writer FSM, FILL state (wr_ready=1):
  - On acceptance of beat number DEPTH (wcnt==DEPTH-1):
    - If bank_ready==0, or rd_release is asserted in the same cycle: swap next edge (bank_ready=1, rd_bank=wr_bank, wr_bank toggles, wcnt=0), stay in FILL.
    - Otherwise go to HOLD, wcnt=0.
- Writer FSM, HOLD state (wr_ready=0):
  - On rd_release: swap next edge, return to FILL.
  - Otherwise remain in HOLD.
- rd_release outside a swap:
  - With bank_ready=1 and no swap in that cycle: bank_ready=0 next edge.
  - With bank_ready=0: ignored.
- Read path, latency exactly 1 cycle:
  - rd_en && bank_ready, all indices in range: next edge rd_data=mem[rd_bank][addr], rd_valid=1, err_oob=0.
  - rd_en && bank_ready, any index ≥ its Dn: rd_data=0, rd_valid=1, err_oob=1.
  - rd_en && !bank_ready: rd_valid=0, err_oob=0, rd_data holds its previous value.
  - rd_valid and err_oob are 1-cycle pulses and are 0 when there is no request.
  - rd_en together with rd_release, or with a swap, in the same cycle: the read samples the bank that was readable before that edge.
- Address arithmetic is performed at AW+1 bits after the range check; no wrap-around.
- The write counter cannot wrap: after the last beat it resets to 0 as part of the swap or HOLD transition.
- Reset mid-fill: partial tensor discarded. Reset while HOLD or bank_ready: both banks are treated as empty.
- Throughput: 1 write and 1 read per cycle sustained; no bubble on swap when the read bank is free.

Test Plan:
1. Params D0=2, D1=3, D2=2, D3=2 (DEPTH=24). Write 0..23 back-to-back → the edge after beat 24 gives bank_ready=1, rd_bank=0, wr_bank=1, wr_ready=1. Read (1,2,1,0) → next cycle rd_data=22, rd_valid=1, err_oob=0.
2. Without releasing, write 100..123 → after beat 24 wr_ready=0 (HOLD). Reads still return bank-0 data. Pulse rd_release → next edge rd_bank=1, wr_ready=1, bank_ready=1. Read (0,0,0,1) → rd_data=101.
3. bank_ready=1 and rd_release asserted on the same cycle as the 24th write → direct swap with no HOLD cycle. wr_ready stays 1 throughout.
4. Read (0,3,0,0), i.e. D1 out of range → rd_data=0, rd_valid=1, err_oob=1 for exactly 1 cycle. The following in-range read has err_oob=0.
5. Accept 10 beats with random wr_valid gaps, then pulse rst_n low → bank_ready=0, rd_valid=0. A fresh 24-beat load 200..223 then reads back (0,0,0,0)=200 and (1,2,1,1)=223.
6. rd_en with bank_ready=0 right after reset → rd_valid stays 0 and rd_data stays 0. Also rd_en together with rd_release → that read returns the released bank's data, and bank_ready=0 on the next edge.
